// File: rtl/cnn_pkg.sv
// Shared widths and FSM encoding for the CNN datapath address generators.
package cnn_pkg;
    localparam int ADDR_W   = 8;
    localparam int Z_ADDR_W = 7;
    localparam int LEN_W    = 8;
    localparam int K_W      = 4;
    localparam int S_W      = 3;
    localparam int NF_W     = 4;

    typedef enum logic [1:0] {IDLE, RUN, FIN} agu_state_e;
endpackage

// File: rtl/conv_window_agu_if.sv
// Address-beat stream from the window AGU to the scratchpad read ports and MAC/write-back.
interface conv_window_agu_if
    import cnn_pkg::*;
#(
    parameter int ADDR_W   = cnn_pkg::ADDR_W,
    parameter int Z_ADDR_W = cnn_pkg::Z_ADDR_W
);
    logic                rd_valid;
    logic                rd_ready;
    logic [ADDR_W-1:0]   rd_x_adr;
    logic [ADDR_W-1:0]   rd_y_adr;
    logic                tap_first;
    logic                tap_last;
    logic [Z_ADDR_W-1:0] wr_z_adr;

    modport master (output rd_valid, rd_x_adr, rd_y_adr, tap_first, tap_last, wr_z_adr,
                    input  rd_ready);
    modport slave  (input  rd_valid, rd_x_adr, rd_y_adr, tap_first, tap_last, wr_z_adr,
                    output rd_ready);
endinterface

// File: rtl/agu_loop_counter.sv
// Tap / window / filter loop nest. Exposes next-state values so the owner can register
// beat outputs in the same cycle the nest advances.
module agu_loop_counter
    import cnn_pkg::*;
#(
    parameter int ADDR_W   = cnn_pkg::ADDR_W,
    parameter int Z_ADDR_W = cnn_pkg::Z_ADDR_W,
    parameter int LEN_W    = cnn_pkg::LEN_W,
    parameter int K_W      = cnn_pkg::K_W,
    parameter int S_W      = cnn_pkg::S_W,
    parameter int NF_W     = cnn_pkg::NF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                adv,
    input  logic [K_W-1:0]      k,
    input  logic [S_W-1:0]      s,
    input  logic [LEN_W-1:0]    len,
    input  logic [NF_W-1:0]     nf,
    output logic [K_W-1:0]      t_nxt,
    output logic [LEN_W-1:0]    ws_nxt,
    output logic [ADDR_W-1:0]   yoff_nxt,
    output logic [Z_ADDR_W-1:0] zc_nxt,
    output logic                final_beat
);
    logic [K_W-1:0]      t;
    logic [LEN_W-1:0]    ws;
    logic [NF_W-1:0]     f, f_nxt;
    logic [ADDR_W-1:0]   yoff;
    logic [Z_ADDR_W-1:0] zc;
    logic [LEN_W:0]      ws_end;
    logic                t_wrap, ws_wrap, f_wrap;

    // One extra bit so ws+S+K cannot overflow before the compare against L.
    assign ws_end     = {1'b0, ws} + (LEN_W+1)'(s) + (LEN_W+1)'(k);
    assign t_wrap     = (t == k - K_W'(1));
    assign ws_wrap    = (ws_end > {1'b0, len});
    assign f_wrap     = (f == nf - NF_W'(1));
    assign final_beat = t_wrap & ws_wrap & f_wrap;

    always_comb begin
        t_nxt    = t;
        ws_nxt   = ws;
        f_nxt    = f;
        yoff_nxt = yoff;
        zc_nxt   = zc;
        if (init) begin
            t_nxt    = '0;
            ws_nxt   = '0;
            f_nxt    = '0;
            yoff_nxt = '0;
            zc_nxt   = '0;
        end else if (adv) begin
            if (!t_wrap) begin
                t_nxt = t + 1'b1;
            end else begin
                t_nxt  = '0;
                zc_nxt = zc + 1'b1;
                if (!ws_wrap) begin
                    ws_nxt = ws + LEN_W'(s);
                end else begin
                    ws_nxt = '0;
                    // Running f*K offset replaces a multiplier.
                    if (!f_wrap) begin
                        f_nxt    = f + 1'b1;
                        yoff_nxt = yoff + ADDR_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t    <= '0;
            ws   <= '0;
            f    <= '0;
            yoff <= '0;
            zc   <= '0;
        end else begin
            t    <= t_nxt;
            ws   <= ws_nxt;
            f    <= f_nxt;
            yoff <= yoff_nxt;
            zc   <= zc_nxt;
        end
    end
endmodule

// File: rtl/conv_window_agu.sv
// Sliding-window 1D convolution AGU: latches a job on start, streams x/y/z address beats,
// and pulses done (with err for an illegal config).
module conv_window_agu
    import cnn_pkg::*;
#(
    parameter int ADDR_W   = cnn_pkg::ADDR_W,
    parameter int Z_ADDR_W = cnn_pkg::Z_ADDR_W,
    parameter int LEN_W    = cnn_pkg::LEN_W,
    parameter int K_W      = cnn_pkg::K_W,
    parameter int S_W      = cnn_pkg::S_W,
    parameter int NF_W     = cnn_pkg::NF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   x_adr,
    input  logic [ADDR_W-1:0]   y_adr,
    input  logic [Z_ADDR_W-1:0] z_adr,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [K_W-1:0]      cfg_k,
    input  logic [S_W-1:0]      cfg_s,
    input  logic [NF_W-1:0]     cfg_nf,
    output logic                busy,
    output logic                done,
    output logic                err,
    conv_window_agu_if.master   rd
);
    agu_state_e          state;
    logic [ADDR_W-1:0]   xb, yb;
    logic [Z_ADDR_W-1:0] zb;
    logic [K_W-1:0]      k_q;
    logic [S_W-1:0]      s_q;
    logic [LEN_W-1:0]    len_q;
    logic [NF_W-1:0]     nf_q;

    logic                cfg_bad, hs, init, adv, final_beat;
    logic [K_W-1:0]      t_nxt;
    logic [LEN_W-1:0]    ws_nxt;
    logic [ADDR_W-1:0]   yoff_nxt;
    logic [Z_ADDR_W-1:0] zc_nxt;

    assign cfg_bad = (cfg_k == '0) | (cfg_s == '0) | (cfg_nf == '0) |
                     ((LEN_W+1)'(cfg_len) < (LEN_W+1)'(cfg_k));
    assign hs      = rd.rd_valid & rd.rd_ready;
    assign init    = (state == IDLE) & start & ~cfg_bad;
    assign adv     = (state == RUN) & hs;

    agu_loop_counter #(
        .ADDR_W(ADDR_W), .Z_ADDR_W(Z_ADDR_W), .LEN_W(LEN_W),
        .K_W(K_W), .S_W(S_W), .NF_W(NF_W)
    ) u_loop (
        .clk, .rst, .init, .adv,
        .k(k_q), .s(s_q), .len(len_q), .nf(nf_q),
        .t_nxt, .ws_nxt, .yoff_nxt, .zc_nxt, .final_beat
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rd.rd_valid  <= 1'b0;
            rd.rd_x_adr  <= '0;
            rd.rd_y_adr  <= '0;
            rd.wr_z_adr  <= '0;
            rd.tap_first <= 1'b0;
            rd.tap_last  <= 1'b0;
            xb           <= '0;
            yb           <= '0;
            zb           <= '0;
            k_q          <= '0;
            s_q          <= '0;
            len_q        <= '0;
            nf_q         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xb    <= x_adr;
                    yb    <= y_adr;
                    zb    <= z_adr;
                    k_q   <= cfg_k;
                    s_q   <= cfg_s;
                    len_q <= cfg_len;
                    nf_q  <= cfg_nf;
                    if (cfg_bad) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        // Beat 0 is loaded straight from the inputs so valid rises with RUN.
                        state        <= RUN;
                        busy         <= 1'b1;
                        rd.rd_valid  <= 1'b1;
                        rd.rd_x_adr  <= x_adr;
                        rd.rd_y_adr  <= y_adr;
                        rd.wr_z_adr  <= z_adr;
                        rd.tap_first <= 1'b1;
                        rd.tap_last  <= (cfg_k == K_W'(1));
                    end
                end
                RUN: if (hs) begin
                    if (final_beat) begin
                        state        <= FIN;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        rd.rd_valid  <= 1'b0;
                        rd.tap_first <= 1'b0;
                        rd.tap_last  <= 1'b0;
                    end else begin
                        rd.rd_x_adr  <= xb + ADDR_W'(ws_nxt) + ADDR_W'(t_nxt);
                        rd.rd_y_adr  <= yb + yoff_nxt + ADDR_W'(t_nxt);
                        rd.wr_z_adr  <= zb + zc_nxt;
                        rd.tap_first <= (t_nxt == '0);
                        rd.tap_last  <= (t_nxt == k_q - K_W'(1));
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_agu.sv
// Randomised bench for conv_window_agu against a nested-loop reference of the address walk.
module tb_conv_window_agu;
    import cnn_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   x_adr = '0, y_adr = '0;
    logic [Z_ADDR_W-1:0] z_adr = '0;
    logic [LEN_W-1:0]    cfg_len = '0;
    logic [K_W-1:0]      cfg_k = '0;
    logic [S_W-1:0]      cfg_s = '0;
    logic [NF_W-1:0]     cfg_nf = '0;
    logic                busy, done, err;

    conv_window_agu_if rd_if ();

    conv_window_agu dut (
        .clk(clk), .rst(rst), .start(start),
        .x_adr(x_adr), .y_adr(y_adr), .z_adr(z_adr),
        .cfg_len(cfg_len), .cfg_k(cfg_k), .cfg_s(cfg_s), .cfg_nf(cfg_nf),
        .busy(busy), .done(done), .err(err),
        .rd(rd_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    typedef struct {
        int x; int y; int z; bit first; bit last;
    } beat_t;
    beat_t q[$];

    // Expected beat list: for each filter, each full window, each tap.
    task automatic build_model(input int xb, input int yb, input int zb, input int l,
                               input int k, input int s, input int nf, output bit bad);
        int nw;
        beat_t b;
        q.delete();
        bad = (k == 0) || (s == 0) || (nf == 0) || (l < k);
        if (!bad) begin
            nw = (l - k) / s + 1;
            for (int f = 0; f < nf; f++)
                for (int w = 0; w < nw; w++)
                    for (int t = 0; t < k; t++) begin
                        b.x     = (xb + w * s + t) % 256;
                        b.y     = (yb + f * k + t) % 256;
                        b.z     = (zb + f * nw + w) % 128;
                        b.first = (t == 0);
                        b.last  = (t == k - 1);
                        q.push_back(b);
                    end
        end
    endtask

    task automatic run_job(input string tag, input int xb, input int yb, input int zb,
                           input int l, input int k, input int s, input int nf,
                           input int rdy_pct, input int restart_at, input int reset_at);
        bit bad, exp_done;
        build_model(xb, yb, zb, l, k, s, nf, bad);
        @(posedge clk); #1;
        x_adr   = ADDR_W'(xb);   y_adr = ADDR_W'(yb); z_adr = Z_ADDR_W'(zb);
        cfg_len = LEN_W'(l);     cfg_k = K_W'(k);     cfg_s = S_W'(s); cfg_nf = NF_W'(nf);
        start   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_done = bad;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            // A second start mid-run carries a different config that must be ignored.
            start = (cyc == restart_at);
            if (start) begin
                x_adr = ~x_adr; cfg_k = cfg_k + 1'b1; cfg_s = '0;
            end
            rd_if.rd_ready = ($urandom_range(99) < rdy_pct);
            if (cyc == reset_at) begin
                rst = 1'b0;
                #1;
                check({tag, "_rst_busy"},  int'(busy), 0);
                check({tag, "_rst_valid"}, int'(rd_if.rd_valid), 0);
                @(negedge clk);
                check({tag, "_rst_done"},  int'(done), 0);
                rst = 1'b1; start = 1'b0; rd_if.rd_ready = 1'b0;
                return;
            end
            @(negedge clk);
            if (exp_done) begin
                check({tag, "_done"},       int'(done), 1);
                check({tag, "_err"},        int'(err), int'(bad));
                check({tag, "_done_busy"},  int'(busy), 0);
                check({tag, "_done_valid"}, int'(rd_if.rd_valid), 0);
                check({tag, "_beats_left"}, q.size(), 0);
                @(posedge clk); #1;
                start = 1'b0;
                return;
            end
            check({tag, "_done_early"}, int'(done), 0);
            if (cyc == 0) check({tag, "_first_valid"}, int'(rd_if.rd_valid), 1);
            if (rd_if.rd_valid) begin
                if (q.size() == 0) begin
                    check({tag, "_extra_beat"}, int'(rd_if.rd_valid), 0);
                end else begin
                    check({tag, "_x"},     int'(rd_if.rd_x_adr), q[0].x);
                    check({tag, "_y"},     int'(rd_if.rd_y_adr), q[0].y);
                    check({tag, "_first"}, int'(rd_if.tap_first), int'(q[0].first));
                    check({tag, "_last"},  int'(rd_if.tap_last), int'(q[0].last));
                    if (q[0].last) check({tag, "_z"}, int'(rd_if.wr_z_adr), q[0].z);
                    check({tag, "_busy"},  int'(busy), 1);
                    if (rd_if.rd_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) exp_done = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
        end
        check({tag, "_timeout_beats_left"}, q.size(), 0);
        check({tag, "_timeout_done"}, int'(done), 1);
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  int'(busy), 0);
        check("reset_done",  int'(done), 0);
        check("reset_err",   int'(err), 0);
        check("reset_valid", int'(rd_if.rd_valid), 0);
        check("reset_x",     int'(rd_if.rd_x_adr), 0);
        check("reset_y",     int'(rd_if.rd_y_adr), 0);
        check("reset_z",     int'(rd_if.wr_z_adr), 0);
        check("reset_tf",    int'(rd_if.tap_first), 0);
        check("reset_tl",    int'(rd_if.tap_last), 0);
        rst = 1'b1;

        run_job("s1_stride1",   16,   0, 15, 16, 4, 1, 1, 100, -1, -1);
        run_job("s2_stride2",   40,   0,  0, 10, 3, 2, 2, 100, -1, -1);
        run_job("s3_backpress", 16,   0, 15, 16, 4, 1, 1,  50, -1, -1);
        run_job("s4_k_gt_l",    16,   0, 15,  4, 5, 1, 1, 100, -1, -1);
        run_job("s4_s_zero",    16,   0, 15, 16, 4, 0, 1, 100, -1, -1);
        run_job("s4_f_zero",    16,   0, 15, 16, 4, 1, 0, 100, -1, -1);
        run_job("s5_wrap",     254, 255,  0,  4, 2, 1, 1, 100, -1, -1);
        run_job("s6_restart",   16,   0, 15, 16, 4, 1, 1,  70, 10, -1);
        run_job("s6_reset",     16,   0, 15, 16, 4, 1, 1, 100, -1, 20);
        run_job("s6_rerun",     16,   0, 15, 16, 4, 1, 1, 100, -1, -1);

        for (int j = 0; j < 10; j++)
            run_job("rand", int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(127)), int'($urandom_range(40)),
                    int'($urandom_range(8)), int'($urandom_range(7)),
                    int'($urandom_range(3)), int'($urandom_range(100, 30)), -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_window_agu.md
Name: conv_window_agu

Overview:
Parametrised address-generation unit for the CNN datapath's sliding-window 1D convolution. Pulsed by start, it walks every filter, output position and tap, and emits input, filter and output addresses on a valid/ready stream. The stream drives the scratchpad read ports and the MAC/write-back stage. It adds runtime stride, filter length, filter count, backpressure and config-error detection.

Parameters:
ADDR_W, 8, width of x/y (input/filter) addresses
Z_ADDR_W, 7, width of z (output) address
LEN_W, 8, width of input-length config
K_W, 4, width of filter-length config
S_W, 3, width of stride config
NF_W, 4, width of filter-count config

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle launch pulse; ignored unless idle
x_adr  in  ADDR_W  input base address
y_adr  in  ADDR_W  filter base address
z_adr  in  Z_ADDR_W  output base address
cfg_len  in  LEN_W  input length L
cfg_k  in  K_W  filter length K
cfg_s  in  S_W  stride S
cfg_nf  in  NF_W  filter count F
busy  out  1  high from accepted start until done
rd_valid  out  1  address beat valid
rd_ready  in  1  consumer accepts beat
rd_x_adr  out  ADDR_W  input read address
rd_y_adr  out  ADDR_W  filter read address
tap_first  out  1  beat is tap 0 of a window (clear accumulator)
tap_last  out  1  beat is tap K-1 (write result)
wr_z_adr  out  Z_ADDR_W  output write address, meaningful when tap_last
done  out  1  one-cycle completion pulse
err  out  1  registered with done; config illegal

Behaviour:
- Reset (rst=0, async): FSM=IDLE. All outputs are 0. All counters are 0.
- FSM states: IDLE, RUN, FIN.
- IDLE + start=1:
  - Latch all base and cfg inputs.
  - If K=0, S=0, F=0 or L<K: go to FIN with err latched at 1.
  - Otherwise: go to RUN, busy=1, f=0, ws=0, t=0, zc=0.
  - start in any other state is ignored, and the latched config is unchanged.
- RUN: beat outputs are registered, and rd_valid=1 from the first cycle in RUN.
  - rd_x_adr = xb + ws + t
  - rd_y_adr = yb + f*K + t. Keep a running filter offset; no multiplier.
  - wr_z_adr = zb + zc
  - tap_first = (t==0)
  - tap_last = (t==K-1)
- Advance only on handshake (rd_valid & rd_ready). With rd_ready=0 all beat outputs hold stable.
- Advance order:
  - t<K-1: t++.
  - Else: t=0, zc++. Then:
    - If ws+S+K<=L: ws+=S.
    - Else ws=0, and either f++ (if f<F-1) or the final beat is done.
- Final beat accepted: rd_valid=0 next cycle and FSM=FIN.
- FIN: done=1 for exactly one cycle, err valid in the same cycle, busy=0 in that cycle, then IDLE.
  - Error path: done pulses in the cycle after start, with zero beats issued.
- Window-count comparison is done at LEN_W+1 bits (no overflow).
- Address sums wrap modulo 2^ADDR_W / 2^Z_ADDR_W.
- Windows per filter = floor((L-K)/S)+1. Tail samples short of a full window are dropped.
- Throughput: one beat per cycle under continuous rd_ready. No bubble between windows or filters.
- Reset mid-RUN aborts immediately: no done pulse, and the next start runs cleanly.

Decomposition:
- Shared package cnn_pkg holds:
  - Default widths ADDR_W, Z_ADDR_W, LEN_W, K_W, S_W, NF_W.
  - FSM state enum {IDLE, RUN, FIN}.
- Sub-module agu_loop_counter: tap/window/filter nest with an advance input, wrap flags and running offsets.
- The top holds FSM, config latch, output registers and error check.

Test Plan:
1. Single filter, stride 1: L=16, K=4, S=1, F=1, x=16, y=0, z=15, rd_ready=1.
   - Expect 13 windows / 52 beats.
   - Beat0: x=16, y=0, tap_first=1.
   - Last beat: x=31, y=3, z=27, tap_last=1.
   - done one cycle after the last handshake, err=0.
2. Stride 2, two filters: L=10, K=3, S=2, F=2, y=0, z=0.
   - Windows ws=0,2,4,6 per filter.
   - Filter-1 y addresses 3..5.
   - z values on tap_last: 0..7 in order. 24 beats total.
3. Backpressure: scenario 1 with rd_ready toggled by pseudo-random bits.
   - Beat sequence identical to scenario 1.
   - Outputs stable while rd_valid&!rd_ready.
   - busy high until done.
4. Illegal configs:
   - K=5, L=4: done+err=1 in the cycle after start, rd_valid never 1.
   - Repeat with S=0 and F=0: same result.
5. Wrap: x=254, y=255, L=4, K=2, S=1, F=1.
   - x sequence 254,255,255,0,0,1.
   - y sequence 255,0 repeating.
6. Start while busy, and reset mid-run:
   - Second start mid-RUN changes nothing.
   - rst=0 mid-RUN: busy/rd_valid go to 0 immediately, no done pulse.
   - A fresh start then reproduces scenario 1 exactly.
